// File: rtl/msrh_l2_line_responder_if.sv
// L2 request/response channel interfaces used by msrh_l2_line_responder.
//   l2_req_if  : valid/ready handshake carrying {cmd, addr, tag, data, byte_en}.
//                master drives valid/payload, slave drives ready.
//   l2_resp_if : valid/ready handshake carrying {tag, data}.
//                master drives valid/payload, slave drives ready.
interface l2_req_if #(
    parameter int ADDR_W = 56,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 256
);
    localparam int DATA_B = DATA_W / 8;

    typedef struct packed {
        logic [4:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [DATA_B-1:0] byte_en;
    } payload_t;

    logic     valid;
    logic     ready;
    payload_t payload;

    modport master (output valid, output payload, input  ready);
    modport slave  (input  valid, input  payload, output ready);
endinterface

interface l2_resp_if #(
    parameter int TAG_W  = 8,
    parameter int DATA_W = 256
);
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } payload_t;

    logic     valid;
    logic     ready;
    payload_t payload;

    modport master (output valid, output payload, input  ready);
    modport slave  (input  valid, input  payload, output ready);
endinterface

// File: rtl/msrh_l2_line_responder.sv
// Responder end of the L2 line protocol. Services reads and byte-masked
// writes from an internal line-wide memory and returns read responses in
// accept order, each no earlier than LATENCY cycles after its accept.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   l2_req           : request channel (ready driven here)
//   l2_resp          : response channel (valid/payload driven here)
//   o_err_cmd        : one-cycle pulse after an unsupported cmd is accepted
//   o_outstanding    : number of queued read responses
module msrh_l2_line_responder #(
    parameter int DATA_W      = 256,
    parameter int ADDR_W      = 56,
    parameter int TAG_W       = 8,
    parameter int WORDS       = 1024,
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    l2_req_if.slave                          l2_req,
    l2_resp_if.master                        l2_resp,
    output logic                             o_err_cmd,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_outstanding
);
    localparam int DATA_B = DATA_W / 8;
    localparam int OFF_W  = $clog2(DATA_B);
    localparam int IDX_W  = $clog2(WORDS);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int AGE_W  = $clog2(LATENCY + 1);

    localparam logic [4:0] M_XRD = 5'b00000;
    localparam logic [4:0] M_XWR = 5'b00001;

    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       rptr;
    logic [PTR_W-1:0]       wptr;
    logic [QUEUE_DEPTH-1:0] q_vld;
    logic [AGE_W-1:0]       q_age  [QUEUE_DEPTH];
    logic [TAG_W-1:0]       q_tag  [QUEUE_DEPTH];
    logic [DATA_W-1:0]      q_data [QUEUE_DEPTH];

    logic [IDX_W-1:0]       idx;
    logic [DATA_W-1:0]      rd_line;
    logic                   accept;
    logic                   rd_acc;
    logic                   wr_acc;
    logic                   bad_acc;
    logic                   resp_vld;
    logic                   pop;

    // Ready looks only at the registered count, so a pop in the same cycle
    // never opens a slot for a same-cycle accept.
    assign l2_req.ready = (count < CNT_W'(QUEUE_DEPTH));
    assign accept       = l2_req.valid & l2_req.ready;
    assign idx          = l2_req.payload.addr[OFF_W +: IDX_W];
    assign rd_acc       = accept & (l2_req.payload.cmd == M_XRD);
    assign wr_acc       = accept & (l2_req.payload.cmd == M_XWR);
    assign bad_acc      = accept & ~rd_acc & ~wr_acc;

    // Address bits outside the line index are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^l2_req.payload.addr;

    // One byte-wide bank per byte lane keeps the masked write a plain
    // per-bank enable. Contents are not reset.
    for (genvar b = 0; b < DATA_B; b++) begin : g_bank
        logic [7:0] bank [WORDS];

        always_ff @(posedge i_clk) begin
            if (wr_acc && l2_req.payload.byte_en[b])
                bank[idx] <= l2_req.payload.data[b*8 +: 8];
        end

        assign rd_line[b*8 +: 8] = bank[idx];
    end

    // Head is presentable only once it has aged LATENCY cycles; q_vld of the
    // head doubles as the queue-non-empty flag.
    assign resp_vld = q_vld[rptr] && (q_age[rptr] == AGE_W'(LATENCY));
    assign pop      = resp_vld & l2_resp.ready;

    assign l2_resp.valid        = resp_vld;
    assign l2_resp.payload.tag  = resp_vld ? q_tag[rptr]  : '0;
    assign l2_resp.payload.data = resp_vld ? q_data[rptr] : '0;
    assign o_outstanding        = count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count     <= '0;
            rptr      <= '0;
            wptr      <= '0;
            q_vld     <= '0;
            o_err_cmd <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) q_age[i] <= '0;
        end else begin
            o_err_cmd <= bad_acc;
            if (rd_acc) wptr <= wptr + PTR_W'(1);
            if (pop)    rptr <= rptr + PTR_W'(1);
            case ({rd_acc, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
            // A push slot and the popped head can never coincide: a push
            // needs a free slot, a pop needs a non-empty queue, and with the
            // pointers equal only one of those holds.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (rd_acc && (wptr == PTR_W'(i))) begin
                    q_vld[i] <= 1'b1;
                    q_age[i] <= AGE_W'(1);
                end else if (pop && (rptr == PTR_W'(i))) begin
                    q_vld[i] <= 1'b0;
                end else if (q_vld[i] && (q_age[i] != AGE_W'(LATENCY))) begin
                    q_age[i] <= q_age[i] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (rd_acc) begin
            q_tag[wptr]  <= l2_req.payload.tag;
            q_data[wptr] <= rd_line;
        end
    end
endmodule
